// File: rtl/minesweeper_pkg.sv
// Shared constants and types for the minesweeper board RAM access path.
package minesweeper_pkg;

  localparam int ADDR_W        = 8;    // cell address width
  localparam int DATA_W        = 7;    // cell word width
  localparam int NUM_CELLS     = 256;  // cells swept by a board clear
  localparam int DISP_MAX_WAIT = 3;    // display denials before a forced grant

  localparam logic [DATA_W-1:0] CLEAR_VALUE = '0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/board_ram_arbiter_if.sv
// Bundle of the clear, processor, display and RAM-side signals of the arbiter.
interface board_ram_arbiter_if;
  import minesweeper_pkg::*;

  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;

  logic              proc_req;
  logic              proc_we;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic              proc_gnt;
  logic              proc_rvalid;
  logic [DATA_W-1:0] proc_rdata;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  clear_req, proc_req, proc_we, proc_addr, proc_wdata,
    input  disp_req, disp_addr, ram_rdata,
    output clear_busy, clear_done, proc_gnt, proc_rvalid, proc_rdata,
    output disp_gnt, disp_rvalid, disp_rdata, ram_addr, ram_we, ram_wdata
  );

  // Requester / RAM side
  modport master (
    output clear_req, proc_req, proc_we, proc_addr, proc_wdata,
    output disp_req, disp_addr, ram_rdata,
    input  clear_busy, clear_done, proc_gnt, proc_rvalid, proc_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/board_clear_seq.sv
// Board-clear sequencer: sweeps every cell address once, one per cycle.
module board_clear_seq
  import minesweeper_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear_req,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_addr
);

  // One extra bit so a full 2^ADDR_W sweep reaches its last cell without wrapping.
  localparam int              CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CELLS - 1);

  clr_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // FSM: a pulse in IDLE starts a sweep; requests arriving mid-sweep are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_clear_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= (NUM_CELLS == 1);
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_done <= ((r_cnt + CNT_W'(1)) == LAST);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_addr = r_cnt[ADDR_W-1:0];

endmodule

// File: rtl/board_ram_arbiter.sv
// Single-port board RAM arbiter: processor, display scanner and clear sweep.
module board_ram_arbiter
  import minesweeper_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  board_ram_arbiter_if.slave bus
);

  localparam int                WAIT_W   = (DISP_MAX_WAIT < 1) ? 1 : $clog2(DISP_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DISP_MAX_WAIT);

  logic              w_busy;
  logic              w_done;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_arb_en;
  logic              w_disp_force;
  logic              w_proc_gnt;
  logic              w_disp_gnt;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_wdata;

  logic [WAIT_W-1:0] r_wait;
  logic              r_proc_rvalid;
  logic              r_disp_rvalid;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_wdata;

  board_clear_seq u_clear_seq (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_clear_req (bus.clear_req),
    .o_busy      (w_busy),
    .o_done      (w_done),
    .o_addr      (w_sweep_addr)
  );

  // Grant decision: processor first unless the display has starved long enough.
  // Reset is folded in so no grant can leak out while it is asserted.
  always_comb begin
    w_arb_en     = !reset && !w_busy && !bus.clear_req;
    w_disp_force = bus.disp_req && (r_wait == WAIT_MAX);
    w_proc_gnt   = w_arb_en && bus.proc_req && !w_disp_force;
    w_disp_gnt   = w_arb_en && bus.disp_req && !w_proc_gnt;
  end

  // RAM port mux; with no access the address and data hold their last values.
  always_comb begin
    w_ram_addr  = r_last_addr;
    w_ram_wdata = r_last_wdata;
    w_ram_we    = 1'b0;
    if (w_busy) begin
      w_ram_addr  = w_sweep_addr;
      w_ram_wdata = CLEAR_VALUE;
      w_ram_we    = 1'b1;
    end else if (w_proc_gnt) begin
      w_ram_addr  = bus.proc_addr;
      w_ram_wdata = bus.proc_wdata;
      w_ram_we    = bus.proc_we;
    end else if (w_disp_gnt) begin
      w_ram_addr  = bus.disp_addr;
    end
  end

  // Display starvation counter, frozen while the sweep owns the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if (!w_busy) begin
      if (!bus.disp_req || w_disp_gnt) begin
        r_wait <= '0;
      end else if (r_wait != WAIT_MAX) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
    end
  end

  // Read-return flags line up with the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_proc_rvalid <= 1'b0;
      r_disp_rvalid <= 1'b0;
    end else begin
      r_proc_rvalid <= w_proc_gnt && !bus.proc_we;
      r_disp_rvalid <= w_disp_gnt;
    end
  end

  // Remember the last driven address/data so an idle port does not toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else begin
      r_last_addr  <= w_ram_addr;
      r_last_wdata <= w_ram_wdata;
    end
  end

  assign bus.clear_busy  = w_busy;
  assign bus.clear_done  = w_done;
  assign bus.proc_gnt    = w_proc_gnt;
  assign bus.disp_gnt    = w_disp_gnt;
  assign bus.proc_rvalid = r_proc_rvalid;
  assign bus.disp_rvalid = r_disp_rvalid;
  assign bus.proc_rdata  = bus.ram_rdata;
  assign bus.disp_rdata  = bus.ram_rdata;
  assign bus.ram_addr    = w_ram_addr;
  assign bus.ram_we      = w_ram_we;
  assign bus.ram_wdata   = w_ram_wdata;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Scoreboard bench for board_ram_arbiter with a behavioural RAM and reference model.
module tb_board_ram_arbiter;
  import minesweeper_pkg::*;

  typedef struct {
    int                cyc;
    bit                busy;
    bit                done;
    bit                we;
    bit                pg;
    bit                dg;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } stat_t;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  board_ram_arbiter_if bus ();
  board_ram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM: synchronous write, registered read (data one cycle after address).
  logic [DATA_W-1:0] mem [NUM_CELLS];
  always @(posedge clk) begin
    bus.ram_rdata <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [NUM_CELLS];
  int                clr_left  = 0;   // cells still to be swept
  int                streak    = 0;   // consecutive display denials
  logic [ADDR_W-1:0] last_addr = '0;
  bit                last_pg   = 1'b0;
  bit                last_dg   = 1'b0;
  stat_t             q_stat [$];
  rd_t               q_prd  [$];
  rd_t               q_drd  [$];

  // Directed request overrides, applied when the requester is free
  bit                np_set = 1'b0;
  bit                np_we  = 1'b0;
  logic [ADDR_W-1:0] np_addr = '0;
  logic [DATA_W-1:0] np_wdata = '0;
  bit                nd_set = 1'b0;
  logic [ADDR_W-1:0] nd_addr = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endfunction

  // Expected port behaviour for the current cycle, from the arbitration rules.
  task automatic model_step(output stat_t s);
    int  a;
    rd_t r;
    s.cyc = cyc; s.busy = 0; s.done = 0; s.we = 0; s.pg = 0; s.dg = 0;
    s.addr = last_addr; s.wdata = '0;
    if (reset) begin
      clr_left = 0;
      streak   = 0;
      s.addr   = '0;
    end else if (clr_left > 0) begin
      a       = NUM_CELLS - clr_left;
      s.busy  = 1; s.done = (clr_left == 1); s.we = 1;
      s.addr  = ADDR_W'(a);
      s.wdata = CLEAR_VALUE;
      ref_mem[a] = CLEAR_VALUE;
      clr_left--;
    end else begin
      if (bus.clear_req)                                clr_left = NUM_CELLS;
      else if (bus.disp_req && streak >= DISP_MAX_WAIT) s.dg = 1;
      else if (bus.proc_req)                            s.pg = 1;
      else if (bus.disp_req)                            s.dg = 1;
      if (s.pg) begin
        s.addr = bus.proc_addr;
        if (bus.proc_we) begin
          s.we = 1; s.wdata = bus.proc_wdata;
          ref_mem[bus.proc_addr] = bus.proc_wdata;
        end else begin
          r.cyc = cyc + 1; r.data = ref_mem[bus.proc_addr];
          q_prd.push_back(r);
        end
      end
      if (s.dg) begin
        s.addr = bus.disp_addr;
        r.cyc = cyc + 1; r.data = ref_mem[bus.disp_addr];
        q_drd.push_back(r);
      end
      if (bus.disp_req && !s.dg) streak = (streak < DISP_MAX_WAIT) ? streak + 1 : streak;
      else                       streak = 0;
    end
    last_addr = s.addr;
    q_stat.push_back(s);
  endtask

  task automatic apply_reqs(input int pp, input int pd);
    if (last_pg) bus.proc_req = 1'b0;
    if (last_dg) bus.disp_req = 1'b0;
    if (!bus.proc_req) begin
      if (np_set) begin
        bus.proc_req = 1'b1; bus.proc_we = np_we; bus.proc_addr = np_addr; bus.proc_wdata = np_wdata;
      end else if (int'($urandom_range(0, 99)) < pp) begin
        bus.proc_req   = 1'b1;
        bus.proc_we    = 1'($urandom_range(0, 1));
        bus.proc_addr  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
        bus.proc_wdata = DATA_W'($urandom);
      end
    end
    np_set = 1'b0;
    if (!bus.disp_req) begin
      if (nd_set) begin
        bus.disp_req = 1'b1; bus.disp_addr = nd_addr;
      end else if (int'($urandom_range(0, 99)) < pd) begin
        bus.disp_req  = 1'b1;
        bus.disp_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      end
    end
    nd_set = 1'b0;
  endtask

  task automatic drive_cycle(input bit rst_v, input bit clr, input int pp, input int pd);
    stat_t s;
    @(posedge clk); #1;
    reset = rst_v;
    apply_reqs(pp, pd);
    bus.clear_req = clr;
    model_step(s);
    last_pg = s.pg; last_dg = s.dg;
  endtask

  // Raise reset partway through the cycle that sweeps cell 0x80.
  task automatic reset_mid_sweep();
    stat_t s;
    @(posedge clk); #1;
    apply_reqs(0, 0);
    bus.clear_req = 1'b0;
    chk("pre_rst_busy", bus.clear_busy, 1);
    chk("pre_rst_ram_we", bus.ram_we, 1);
    chk("pre_rst_ram_addr", bus.ram_addr, 32'h80);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", bus.clear_busy, 0);
    chk("async_rst_ram_we", bus.ram_we, 0);
    chk("async_rst_proc_gnt", bus.proc_gnt, 0);
    chk("async_rst_disp_gnt", bus.disp_gnt, 0);
    chk("async_rst_ram_addr", bus.ram_addr, 0);
    model_step(s);
    last_pg = s.pg; last_dg = s.dg;
  endtask

  // Monitor: every cycle pop the expected port state; pop read data on rvalid.
  stat_t m_s;
  rd_t   m_r;
  always @(negedge clk) begin
    if (q_stat.size() > 0) begin
      m_s = q_stat.pop_front();
      chk("clear_busy", bus.clear_busy, m_s.busy);
      chk("clear_done", bus.clear_done, m_s.done);
      chk("proc_gnt", bus.proc_gnt, m_s.pg);
      chk("disp_gnt", bus.disp_gnt, m_s.dg);
      chk("ram_we", bus.ram_we, m_s.we);
      chk("ram_addr", bus.ram_addr, m_s.addr);
      if (m_s.we) chk("ram_wdata", bus.ram_wdata, m_s.wdata);
    end
    if (q_prd.size() > 0 && q_prd[0].cyc <= cyc) begin
      m_r = q_prd.pop_front();
      chk("proc_rvalid", bus.proc_rvalid, 1);
      if (bus.proc_rvalid) chk("proc_rdata", bus.proc_rdata, m_r.data);
    end else if (bus.proc_rvalid) begin
      chk("proc_rvalid_unexpected", bus.proc_rvalid, 0);
    end
    if (q_drd.size() > 0 && q_drd[0].cyc <= cyc) begin
      m_r = q_drd.pop_front();
      chk("disp_rvalid", bus.disp_rvalid, 1);
      if (bus.disp_rvalid) chk("disp_rdata", bus.disp_rdata, m_r.data);
    end else if (bus.disp_rvalid) begin
      chk("disp_rvalid_unexpected", bus.disp_rvalid, 0);
    end
  end

  initial begin
    bus.clear_req = 1'b0; bus.proc_req = 1'b0; bus.proc_we = 1'b0;
    bus.proc_addr = '0;   bus.proc_wdata = '0; bus.disp_req = 1'b0; bus.disp_addr = '0;

    // Reset with a processor write held: no grant until reset drops.
    np_set = 1; np_we = 1; np_addr = 8'h33; np_wdata = 7'h11;
    repeat (3) drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);

    // Full sweep; a second clear pulse inside the sweep is ignored.
    drive_cycle(0, 1, 0, 0);
    for (int i = 0; i < NUM_CELLS + 2; i++) drive_cycle(0, (i == 10), 0, 0);

    // Processor write then read-back of 0x12.
    np_set = 1; np_we = 1; np_addr = 8'h12; np_wdata = 7'h45;
    drive_cycle(0, 0, 0, 0);
    np_set = 1; np_we = 0; np_addr = 8'h12;
    repeat (3) drive_cycle(0, 0, 0, 0);

    // Simultaneous processor and display reads.
    np_set = 1; np_we = 0; np_addr = 8'h10;
    nd_set = 1; nd_addr = 8'h20;
    repeat (4) drive_cycle(0, 0, 0, 0);

    // Both requesters continuously busy: display forced in every fourth slot.
    for (int i = 0; i < 12; i++) begin
      np_set = 1; np_we = 0; np_addr = ADDR_W'(i);
      nd_set = 1; nd_addr = ADDR_W'(8'h20 + i);
      drive_cycle(0, 0, 0, 0);
    end
    repeat (4) drive_cycle(0, 0, 0, 0);

    // Clear arrives together with a processor write; the write lands after the sweep.
    np_set = 1; np_we = 1; np_addr = 8'h05; np_wdata = 7'h2A;
    drive_cycle(0, 1, 0, 0);
    repeat (NUM_CELLS + 3) drive_cycle(0, 0, 0, 0);
    np_set = 1; np_we = 0; np_addr = 8'h05;
    repeat (3) drive_cycle(0, 0, 0, 0);

    // Random traffic with occasional clears.
    repeat (800) drive_cycle(0, ($urandom_range(0, 199) == 0), 60, 50);
    repeat (NUM_CELLS + 10) drive_cycle(0, 0, 0, 0);

    // Sweep aborted by reset at cell 0x80 with a processor write pending.
    drive_cycle(0, 1, 0, 0);
    repeat (128) drive_cycle(0, 0, 0, 0);
    np_set = 1; np_we = 1; np_addr = 8'h90; np_wdata = 7'h3C;
    reset_mid_sweep();
    repeat (2) drive_cycle(1, 0, 0, 0);
    repeat (6) drive_cycle(0, 0, 0, 0);
    np_set = 1; np_we = 0; np_addr = 8'h7F; drive_cycle(0, 0, 0, 0);
    np_set = 1; np_we = 0; np_addr = 8'h80; drive_cycle(0, 0, 0, 0);
    np_set = 1; np_we = 0; np_addr = 8'h81; drive_cycle(0, 0, 0, 0);
    np_set = 1; np_we = 0; np_addr = 8'h90; drive_cycle(0, 0, 0, 0);
    repeat (4) drive_cycle(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("pending_status", q_stat.size(), 0);
    chk("pending_proc_reads", q_prd.size(), 0);
    chk("pending_disp_reads", q_drd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
Single-port access controller for the minesweeper board RAM (256 cells × 7-bit cell word). It shares one RAM address/write port between three users:
- the game processor (read/write);
- the VGA display scanner (read-only);
- an internal board-clear sequencer that sweeps every cell to a constant.

It sits between the processor, the display logic and minesweeper_RAM. It replaces the direct processor-to-RAM wiring and the RAM's own reset-clear.

Parameters:
ADDR_W, 8, cell address width
DATA_W, 7, cell word width
NUM_CELLS, 256, cells swept by a clear (≤ 2^ADDR_W)
CLEAR_VALUE, 0, word written to every cell during a clear
DISP_MAX_WAIT, 3, consecutive display denials before the display is forced a grant

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear_req  in  1  one-cycle pulse: start a board clear
clear_busy  out  1  high while a sweep is in progress
clear_done  out  1  one-cycle pulse on the final sweep write
proc_req  in  1  processor access request; held until granted
proc_we  in  1  1 = write, 0 = read
proc_addr  in  ADDR_W  processor cell address
proc_wdata  in  DATA_W  processor write data
proc_gnt  out  1  processor access performed this cycle
proc_rvalid  out  1  proc_rdata valid (read only)
proc_rdata  out  DATA_W  processor read data
disp_req  in  1  display read request; held until granted
disp_addr  in  ADDR_W  display cell address
disp_gnt  out  1  display access performed this cycle
disp_rvalid  out  1  disp_rdata valid
disp_rdata  out  DATA_W  display read data
ram_addr  out  ADDR_W  to RAM read_addr and write_addr
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after its address

Behaviour:
- Reset (asynchronous, active-high) drives the block to:
  - state IDLE, sweep counter 0, wait counter 0;
  - clear_busy, clear_done, both rvalids 0;
  - gnt outputs and ram_we forced 0 while reset is high;
  - ram_addr and ram_wdata 0.
- FSM has two states, IDLE and CLEAR.
- IDLE, clear_req = 1:
  - no grants that cycle and ram_we = 0;
  - next state is CLEAR with sweep counter 0.
- IDLE, clear_req = 0: arbitrate.
  - Processor has fixed priority.
  - Exception: if the display has been denied DISP_MAX_WAIT consecutive requesting cycles, the display wins this cycle.
  - The wait counter increments on each cycle with disp_req = 1 and disp_gnt = 0.
  - It clears on disp_gnt or when disp_req = 0, and saturates at DISP_MAX_WAIT.
- A grant is combinational, in the same cycle as the request:
  - ram_addr, ram_we and ram_wdata are muxed from the winner;
  - display accesses are always reads (ram_we = 0).
- With no request: ram_we = 0 and ram_addr holds its last value.
- Read return:
  - proc_rvalid is registered, high exactly 1 cycle after a proc_gnt with proc_we = 0;
  - disp_rvalid is registered, high exactly 1 cycle after a disp_gnt;
  - the rdata outputs are ram_rdata passed through, meaningful only while the matching rvalid is high;
  - a write grant produces no rvalid.
- Back-to-back grants are allowed every cycle. One grant per cycle maximum; proc_gnt and disp_gnt are never both high.
- CLEAR state, one write per cycle:
  - ram_we = 1, ram_addr = sweep counter, ram_wdata = CLEAR_VALUE;
  - sweep counter increments each cycle;
  - no grants; requesters simply wait with req held.
- clear_busy is high on exactly the NUM_CELLS CLEAR cycles.
- clear_done pulses in the cycle writing address NUM_CELLS-1; the next state is IDLE.
- clear_req received during CLEAR is ignored; no restart and no queuing.
- Wait counter is frozen during CLEAR.
- Reset mid-sweep aborts the sweep immediately. There is no resumption; cells are left partially cleared.
- Address width rule: the sweep counter is ADDR_W+1 bits so NUM_CELLS = 2^ADDR_W terminates without wrap; ram_addr takes its low ADDR_W bits.

Decomposition:
- Shared package (minesweeper_pkg) holds:
  - cell-word width and board-size constants (ADDR_W, DATA_W, NUM_CELLS);
  - the FSM state enum;
  - CLEAR_VALUE.
- The clear sequencer (FSM, sweep counter, clear_done) is one natural sub-module, board_clear_seq.
- Arbitration, wait counter and rvalid registers stay in the top module.

Test Plan:
1. Reset, then clear_req pulse → next cycle clear_busy = 1 for 256 cycles; ram_we = 1 with ram_addr 0x00..0xFF in order and ram_wdata = 0; clear_done only at 0xFF; IDLE afterwards.
2. proc_req with proc_we = 1, addr 0x12, data 0x45 → proc_gnt = 1 the same cycle with ram_addr 0x12, ram_we = 1, ram_wdata 0x45; no proc_rvalid. Then a read of 0x12 → proc_rvalid 1 cycle after grant with proc_rdata 0x45.
3. proc read 0x10 and disp read 0x20 in the same cycle → proc_gnt in cycle 0; disp_gnt in cycle 1 (ram_addr 0x20); disp_rvalid in cycle 2 with RAM contents.
4. proc_req and disp_req both held continuously → disp denied cycles 0–2, disp_gnt in cycle 3, proc_gnt resumes in cycle 4; the pattern repeats every 4 cycles.
5. clear_req in the same cycle as proc_req (write 0x05) → no grant that cycle; sweep runs; proc_gnt occurs only in the first IDLE cycle after clear_busy falls, and that write survives.
6. Assert reset mid-sweep at ram_addr 0x80 → clear_busy, ram_we and all gnt outputs are 0 immediately (asynchronous); after release the FSM stays IDLE and the sweep does not resume.
